// File: rtl/acumulador_controlado_pkg.sv
// rtl/acumulador_controlado_pkg.sv - shared types and constants for the accumulator and its adder
package acumulador_controlado_pkg;

    localparam int LARGURA_PADRAO = 5;

    typedef enum logic [0:0] {
        ACUMULANDO = 1'b0,
        ENTREGANDO = 1'b1
    } estado_t;

endpackage

// File: rtl/acumulador_controlado_if.sv
// rtl/acumulador_controlado_if.sv - operand input and result output handshakes of the accumulator
interface acumulador_controlado_if
    import acumulador_controlado_pkg::*;
#(
    parameter int LARGURA = LARGURA_PADRAO
);
    logic               entrada_valida;
    logic               entrada_pronta;
    logic [LARGURA-1:0] dado;
    logic               subtrair;
    logic               saida_valida;
    logic               saida_pronta;
    logic [LARGURA-1:0] resultado;
    logic               carry;
    logic               estouro;

    modport master (
        output entrada_valida, dado, subtrair, saida_pronta,
        input  entrada_pronta, saida_valida, resultado, carry, estouro
    );

    modport slave (
        input  entrada_valida, dado, subtrair, saida_pronta,
        output entrada_pronta, saida_valida, resultado, carry, estouro
    );
endinterface

// File: rtl/acumulador_controlado_unidade_aritmetica.sv
// rtl/acumulador_controlado_unidade_aritmetica.sv - combinational ripple-carry adder
module unidade_aritmetica
    import acumulador_controlado_pkg::*;
#(
    parameter int LARGURA = LARGURA_PADRAO
) (
    input  logic [LARGURA-1:0] a,
    input  logic [LARGURA-1:0] b,
    input  logic               cin,
    output logic [LARGURA-1:0] soma,
    output logic               cout
);
    logic [LARGURA:0] c;

    assign c[0] = cin;

    for (genvar i = 0; i < LARGURA; i++) begin : g_fa
        assign soma[i] = a[i] ^ b[i] ^ c[i];
        assign c[i+1]  = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
    end

    assign cout = c[LARGURA];
endmodule

// File: rtl/acumulador_controlado.sv
// rtl/acumulador_controlado.sv - accumulates N operands (add/sub) then holds result with sticky flags
module acumulador_controlado
    import acumulador_controlado_pkg::*;
#(
    parameter int LARGURA     = LARGURA_PADRAO,
    parameter int N_OPERANDOS = 4
) (
    input  logic                     clock,
    input  logic                     reset,
    acumulador_controlado_if.slave   bus
);
    localparam int CW = $clog2(N_OPERANDOS + 1);
    localparam logic [CW-1:0] ULTIMO = CW'(N_OPERANDOS - 1);

    estado_t            estado;
    estado_t            proximo;
    logic [LARGURA-1:0] acc;
    logic [CW-1:0]      contador;
    logic               carry_r;
    logic               estouro_r;

    logic [LARGURA-1:0] b;
    logic [LARGURA-1:0] soma;
    logic               cout;
    logic               aceita;
    logic               entrega;
    logic               ovf_agora;

    // Subtraction is acc + ~dado + 1, so the adder's carry-in doubles as the "+1".
    assign b = bus.subtrair ? ~bus.dado : bus.dado;

    unidade_aritmetica #(.LARGURA(LARGURA)) u_soma (
        .a    (acc),
        .b    (b),
        .cin  (bus.subtrair),
        .soma (soma),
        .cout (cout)
    );

    assign aceita    = (estado == ACUMULANDO) && bus.entrada_valida;
    assign entrega   = (estado == ENTREGANDO) && bus.saida_pronta;
    assign ovf_agora = (acc[LARGURA-1] == b[LARGURA-1]) && (soma[LARGURA-1] != acc[LARGURA-1]);

    always_ff @(posedge clock) begin
        if (reset) begin
            estado <= ACUMULANDO;
        end else begin
            estado <= proximo;
        end
    end

    always_comb begin
        proximo = estado;
        case (estado)
            ACUMULANDO: if (aceita && (contador == ULTIMO)) proximo = ENTREGANDO;
            ENTREGANDO: if (bus.saida_pronta) proximo = ACUMULANDO;
            default:    proximo = ACUMULANDO;
        endcase
    end

    always_comb begin
        bus.entrada_pronta = 1'b0;
        bus.saida_valida   = 1'b0;
        case (estado)
            ACUMULANDO: bus.entrada_pronta = 1'b1;
            ENTREGANDO: bus.saida_valida   = 1'b1;
            default:    bus.entrada_pronta = 1'b0;
        endcase
    end

    // A completed delivery clears everything so the next batch starts from zero.
    always_ff @(posedge clock) begin
        if (reset || entrega) begin
            acc       <= '0;
            contador  <= '0;
            carry_r   <= 1'b0;
            estouro_r <= 1'b0;
        end else if (aceita) begin
            acc       <= soma;
            contador  <= contador + CW'(1);
            carry_r   <= carry_r | (bus.subtrair ? ~cout : cout);
            estouro_r <= estouro_r | ovf_agora;
        end
    end

    assign bus.resultado = acc;
    assign bus.carry     = carry_r;
    assign bus.estouro   = estouro_r;
endmodule
